inst_sequencer: RTL and testbench

Multi-cycle control sequencer for the 17-bit register-register datapath. Fetches instructions from instruction memory over a req/ack handshake and latches each into a holding register that feeds the decode stage. Steps every instruction through decode, operand read, execute and writeback with one-hot enables. Runs a program from address 0 up to and including a programmed last address, then reports completion.

---
 rtl/inst_sequencer_if.sv | 24 ++
 rtl/inst_sequencer.sv | 146 ++++++++++++++
 tb/tb_inst_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_sequencer_if.sv
// rtl/inst_sequencer_if.sv - instruction-memory fetch handshake (req/addr out, ack/data back)
interface inst_sequencer_if #(
  parameter int INST_LEN = 17,
  parameter int PC_LEN   = 8
);
  logic                imem_req;
  logic [PC_LEN-1:0]   imem_addr;
  logic                imem_ack;
  logic [INST_LEN-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - multi-cycle fetch/decode/read/exec/writeback sequencer
// Optional fetch watchdog and sticky err flag enabled by defining FETCH_TIMEOUT_EN.
module inst_sequencer #(
  parameter int INST_LEN = 17,
  parameter int ADDR_LEN = 5,
  parameter int PC_LEN   = 8
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 15
`endif
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [PC_LEN-1:0]   last_pc,
  inst_sequencer_if.master    imem,
  output logic [INST_LEN-1:0] inst_q,
  output logic                rf_rd_en,
  output logic                alu_en,
  output logic                rf_wr_en,
  output logic [ADDR_LEN-1:0] wr_dest,
  output logic [PC_LEN-1:0]   pc,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [PC_LEN-1:0] last_q;
  logic              at_last;
  logic              launch;
  logic              fetch_ok;
  logic              timeout_hit;

  assign at_last  = (pc == last_q);
  assign launch   = (state == S_IDLE) && start;
  assign fetch_ok = (state == S_FETCH) && imem.imem_ack;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] fetch_cnt;

  // An ack on the limit cycle wins, so the watchdog only fires without ack.
  assign timeout_hit = (state == S_FETCH) && !imem.imem_ack &&
                       (fetch_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_cnt <= '0;
    end else if (state != S_FETCH) begin
      fetch_cnt <= '0;
    end else if (!imem.imem_ack) begin
      fetch_cnt <= fetch_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (launch) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          state_nx = S_DECODE;
        end else if (timeout_hit) begin
          state_nx = S_DONE;
        end
      end
      S_DECODE: state_nx = S_READ;
      S_READ:   state_nx = S_EXEC;
      S_EXEC:   state_nx = S_WB;
      S_WB:     state_nx = at_last ? S_DONE : S_FETCH;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Strobes are pure state decodes, which keeps them one-hot by construction.
  always_comb begin
    imem.imem_req  = (state == S_FETCH);
    imem.imem_addr = pc;
    rf_rd_en       = (state == S_READ);
    alu_en         = (state == S_EXEC);
    rf_wr_en       = (state == S_WB);
    busy           = (state != S_IDLE);
    done           = (state == S_DONE);
  end

  assign wr_dest = inst_q[ADDR_LEN-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc     <= '0;
      last_q <= '0;
      inst_q <= '0;
    end else begin
      if (launch) begin
        pc     <= '0;
        last_q <= last_pc;
      end else if ((state == S_WB) && !at_last) begin
        pc <= pc + 1'b1;
      end
      if (fetch_ok) begin
        inst_q <= imem.imem_data;
      end
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - directed bench for inst_sequencer
module tb_inst_sequencer;
  localparam int INST_LEN = 17;
  localparam int ADDR_LEN = 5;
  localparam int PC_LEN   = 8;

  logic                clk     = 1'b0;
  logic                rstn    = 1'b0;
  logic                start   = 1'b0;
  logic [PC_LEN-1:0]   last_pc = '0;
  logic [INST_LEN-1:0] inst_q;
  logic                rf_rd_en;
  logic                alu_en;
  logic                rf_wr_en;
  logic [ADDR_LEN-1:0] wr_dest;
  logic [PC_LEN-1:0]   pc;
  logic                busy;
  logic                done;
  logic                err;

  inst_sequencer_if #(.INST_LEN(INST_LEN), .PC_LEN(PC_LEN)) imem_bus ();

  inst_sequencer dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .last_pc  (last_pc),
    .imem     (imem_bus),
    .inst_q   (inst_q),
    .rf_rd_en (rf_rd_en),
    .alu_en   (alu_en),
    .rf_wr_en (rf_wr_en),
    .wr_dest  (wr_dest),
    .pc       (pc),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Memory responder: ack after delay_cycles waits on delay_addr, zero-wait elsewhere.
  logic [INST_LEN-1:0] mem [0:255];
  logic                ack_off      = 1'b0;
  logic                force_ack    = 1'b0;
  logic [PC_LEN-1:0]   delay_addr   = '0;
  int                  delay_cycles = 0;
  int                  wcnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) wcnt <= 0;
    else if (imem_bus.imem_req && !imem_bus.imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always_comb begin
    imem_bus.imem_ack  = force_ack ||
                         (!ack_off && imem_bus.imem_req &&
                          ((imem_bus.imem_addr != delay_addr) || (wcnt >= delay_cycles)));
    imem_bus.imem_data = force_ack ? 17'h1_FFFF : mem[imem_bus.imem_addr];
  end

  int                  busy_cnt = 0;
  int                  wr_cnt   = 0;
  int                  req_cnt  = 0;
  int                  req1_cnt = 0;
  logic [PC_LEN-1:0]   addr_log [$];
  logic [ADDR_LEN-1:0] dest_log [$];

  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (rf_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      dest_log.push_back(wr_dest);
    end
    if (imem_bus.imem_req) req_cnt <= req_cnt + 1;
    if (imem_bus.imem_req && imem_bus.imem_addr == 8'd1) req1_cnt <= req1_cnt + 1;
    if (imem_bus.imem_req && imem_bus.imem_ack) addr_log.push_back(imem_bus.imem_addr);
  end

  int   total = 0;
  int   bad   = 0;
  logic spur_en   = 1'b0;
  logic glitch_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string p);
    check({p, "_pc"},       32'(pc), 32'h0);
    check({p, "_inst_q"},   32'(inst_q), 32'h0);
    check({p, "_imem_req"}, 32'(imem_bus.imem_req), 32'h0);
    check({p, "_rd"},       32'(rf_rd_en), 32'h0);
    check({p, "_alu"},      32'(alu_en), 32'h0);
    check({p, "_wr"},       32'(rf_wr_en), 32'h0);
    check({p, "_busy"},     32'(busy), 32'h0);
    check({p, "_done"},     32'(done), 32'h0);
    check({p, "_err"},      32'(err), 32'h0);
  endtask

  // Called at posedge+1 in IDLE; returns just after the start edge (first FETCH cycle).
  task automatic start_run(input logic [PC_LEN-1:0] lp);
    start   = 1'b1;
    last_pc = lp;
    step();
    start   = 1'b0;
    last_pc = 8'hEE;
  endtask

  // cyc numbers busy cycles from 1 (the first FETCH cycle) to the done cycle; -1 on timeout.
  task automatic run_to_done(input int max_cyc, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < max_cyc) begin
      force_ack = spur_en && rf_rd_en;
      start     = glitch_en && (cyc == 7);
      step();
      cyc++;
    end
    force_ack = 1'b0;
    start     = 1'b0;
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic check_addrs(input string p, input int base, input int n);
    check({p, "_addr_count"}, 32'(addr_log.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", p, i), 32'(addr_log[base + i]), 32'(i));
    end
  endtask

  int b_busy, b_wr, b_req, b_req1, b_addr, b_dest, cyc;

  task automatic baseline();
    b_busy = busy_cnt;
    b_wr   = wr_cnt;
    b_req  = req_cnt;
    b_req1 = req1_cnt;
    b_addr = addr_log.size();
    b_dest = dest_log.size();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 17'(i * 3);
    mem[0] = 17'h1_2345;
    mem[1] = 17'h0_0421;
    mem[2] = 17'h1_8C62;
    mem[3] = 17'h0_A9F3;

    step();
    step();
    check_zero("reset");
    rstn = 1'b1;
    step();
    check_zero("idle");

    // Single instruction, zero-wait, cycle by cycle
    baseline();
    start_run(8'd0);
    check("t1_fetch_req",  32'(imem_bus.imem_req), 32'h1);
    check("t1_fetch_addr", 32'(imem_bus.imem_addr), 32'h0);
    check("t1_fetch_busy", 32'(busy), 32'h1);
    step();
    check("t1_dec_inst",   32'(inst_q), 32'h1_2345);
    check("t1_dec_dest",   32'(wr_dest), 32'h05);
    check("t1_dec_strobes", 32'({rf_rd_en, alu_en, rf_wr_en, imem_bus.imem_req}), 32'h0);
    step();
    check("t1_read_strobes", 32'({rf_rd_en, alu_en, rf_wr_en}), 32'b100);
    step();
    check("t1_exec_strobes", 32'({rf_rd_en, alu_en, rf_wr_en}), 32'b010);
    step();
    check("t1_wb_strobes", 32'({rf_rd_en, alu_en, rf_wr_en}), 32'b001);
    check("t1_wb_dest",    32'(wr_dest), 32'h05);
    step();
    check("t1_done",       32'({done, busy}), 32'b11);
    step();
    check("t1_idle",       32'({done, busy}), 32'b00);
    check("t1_busy_cycles", 32'(busy_cnt - b_busy), 32'd6);
    check("t1_inst_hold",  32'(inst_q), 32'h1_2345);
    check("t1_pc",         32'(pc), 32'h0);

    // Four instructions, zero-wait
    baseline();
    start_run(8'd3);
    run_to_done(100, cyc);
    check("t2_done_cycle", 32'(cyc), 32'd21);
    step();
    check_addrs("t2", b_addr, 4);
    check("t2_wr_pulses",  32'(wr_cnt - b_wr), 32'd4);
    check("t2_busy_cycles", 32'(busy_cnt - b_busy), 32'd21);
    check("t2_pc_end",     32'(pc), 32'd3);
    check("t2_inst_end",   32'(inst_q), 32'h0_A9F3);
    check("t2_dest0",      32'(dest_log[b_dest + 0]), 32'h05);
    check("t2_dest1",      32'(dest_log[b_dest + 1]), 32'h01);
    check("t2_dest2",      32'(dest_log[b_dest + 2]), 32'h02);
    check("t2_dest3",      32'(dest_log[b_dest + 3]), 32'h13);

    // Ack delayed 3 cycles at address 1, spurious ack during READ
    baseline();
    delay_addr   = 8'd1;
    delay_cycles = 3;
    spur_en      = 1'b1;
    start_run(8'd2);
    run_to_done(100, cyc);
    check("t3_done_cycle", 32'(cyc), 32'd19);
    step();
    spur_en      = 1'b0;
    delay_cycles = 0;
    check("t3_req_at_1",   32'(req1_cnt - b_req1), 32'd4);
    check("t3_busy_cycles", 32'(busy_cnt - b_busy), 32'd19);
    check_addrs("t3", b_addr, 3);
    check("t3_inst_end",   32'(inst_q), 32'h1_8C62);
    check("t3_pc_end",     32'(pc), 32'd2);

    // Asynchronous reset during EXEC of pc=2, then a fresh run
    start_run(8'd3);
    for (int k = 0; k < 40; k++) begin
      if (alu_en && pc == 8'd2) break;
      step();
    end
    check("t4_in_exec", 32'({alu_en, pc}), 32'h102);
    rstn = 1'b0;
    #1;
    check_zero("t4_async");
    step();
    step();
    rstn = 1'b1;
    step();
    baseline();
    start_run(8'd2);
    run_to_done(100, cyc);
    check("t4_done_cycle", 32'(cyc), 32'd16);
    step();
    check_addrs("t4", b_addr, 3);

    // start pulsed mid-run is ignored
    baseline();
    glitch_en = 1'b1;
    start_run(8'd1);
    run_to_done(100, cyc);
    glitch_en = 1'b0;
    check("t5_done_cycle", 32'(cyc), 32'd11);
    step();
    check("t5_busy_cycles", 32'(busy_cnt - b_busy), 32'd11);
    check_addrs("t5", b_addr, 2);
    check("t5_pc_end",     32'(pc), 32'd1);

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: no ack at all
    baseline();
    ack_off = 1'b1;
    start_run(8'd2);
    run_to_done(60, cyc);
    check("t6_done_cycle", 32'(cyc), 32'd16);
    check("t6_err",        32'(err), 32'h1);
    check("t6_pc",         32'(pc), 32'h0);
    check("t6_req_cycles", 32'(req_cnt - b_req), 32'd15);
    step();
    check("t6_err_sticky", 32'(err), 32'h1);
    ack_off = 1'b0;
    start_run(8'd0);
    check("t6_err_cleared", 32'(err), 32'h0);
    run_to_done(100, cyc);
    check("t6_rerun_done", 32'(cyc), 32'd6);
    step();
`else
    // Without the watchdog FETCH waits indefinitely
    ack_off = 1'b1;
    start_run(8'd2);
    repeat (20) step();
    check("t6_still_req",  32'(imem_bus.imem_req), 32'h1);
    check("t6_still_busy", 32'({busy, done}), 32'b10);
    check("t6_err",        32'(err), 32'h0);
    check("t6_pc",         32'(pc), 32'h0);
    rstn = 1'b0;
    #1;
    check_zero("t6_abandon");
    step();
    rstn    = 1'b1;
    ack_off = 1'b0;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
